// File: rtl/pdm_cic_decimator.sv
// Multi-channel PDM-to-PCM decimator: an order-N CIC per channel with a run-time selectable ratio,
// scaling/saturation to OUT_W bits, and a valid/ready serializer with sticky overrun detection.
module pdm_cic_decimator #(
    parameter int CHANNELS  = 4,
    parameter int CIC_ORDER = 4,
    parameter int OUT_W     = 16
) (
    input  logic                pdm_clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [1:0]          osr_sel,
    input  logic [CHANNELS-1:0] ch_en,
    input  logic [CHANNELS-1:0] pdm_din,
    input  logic                pcm_ready,
    input  logic                ovr_clr,
    output logic                pcm_valid,
    output logic [OUT_W-1:0]    pcm_data,
    output logic [2:0]          pcm_ch,
    output logic                pcm_last,
    output logic                overrun
);

    localparam int ACC_W = 7 * CIC_ORDER + 1;
    // One guard bit so that full-scale +R^N at R=128 is still read as positive.
    localparam int CIC_W = ACC_W + 1;

    typedef logic signed [CIC_W-1:0] acc_t;
    typedef enum logic {IDLE, SEND} state_t;

    localparam acc_t SAT_MAX = acc_t'((longint'(1) <<< (OUT_W - 1)) - 1);
    localparam acc_t SAT_MIN = acc_t'(-(longint'(1) <<< (OUT_W - 1)));

    logic [1:0]          osr_q;
    logic [CHANNELS-1:0] ch_en_q;
    logic [6:0]          dec_cnt;
    logic [6:0]          dec_max;
    logic [2:0]          log2r;
    logic [5:0]          shamt;
    logic [2:0]          warm_cnt;
    logic                tick, tick_d, live_d, comb_valid;

    acc_t integ      [CHANNELS][CIC_ORDER];
    acc_t comb_dly   [CHANNELS][CIC_ORDER];
    acc_t comb_stage [CHANNELS][CIC_ORDER];
    acc_t comb_out   [CHANNELS];

    logic [OUT_W-1:0] scaled [CHANNELS];
    logic [OUT_W-1:0] fbuf   [CHANNELS];

    state_t     state, state_nxt;
    logic [2:0] cur_ch, cur_ch_nxt, first_ch, last_ch, next_ch;
    logic       load, drop;

    // NOTE: always_comb blocks assign every output a default first so no path can infer a latch.
    always_comb begin
        dec_max = 7'd63;
        log2r   = 3'd6;
        case (osr_q)
            2'd0:    begin dec_max = 7'd31;  log2r = 3'd5; end
            2'd2:    begin dec_max = 7'd127; log2r = 3'd7; end
            default: ;
        endcase
        shamt = 6'(CIC_ORDER * int'(log2r) + 1 - OUT_W);
    end

    assign tick = enable && (dec_cnt == dec_max);

    // Configuration tracks the inputs while stopped and is frozen for the whole run.
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge pdm_clk or negedge rst_n) begin
        if (!rst_n) begin
            osr_q   <= '0;
            ch_en_q <= '0;
        end else if (!enable) begin
            osr_q   <= osr_sel;
            ch_en_q <= ch_en;
        end
    end

    always_comb begin
        acc_t x;
        for (int c = 0; c < CHANNELS; c++) begin
            x = integ[c][CIC_ORDER-1];
            for (int k = 0; k < CIC_ORDER; k++) begin
                comb_stage[c][k] = x - comb_dly[c][k];
                x = comb_stage[c][k];
            end
        end
    end

    // NOTE: the CIC arrays are reset and cleared explicitly; a stale integrator never washes out.
    always_ff @(posedge pdm_clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_cnt    <= '0;
            warm_cnt   <= '0;
            tick_d     <= 1'b0;
            live_d     <= 1'b0;
            comb_valid <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                comb_out[c] <= '0;
                for (int k = 0; k < CIC_ORDER; k++) begin
                    integ[c][k]    <= '0;
                    comb_dly[c][k] <= '0;
                end
            end
        end else if (!enable) begin
            dec_cnt    <= '0;
            warm_cnt   <= '0;
            tick_d     <= 1'b0;
            live_d     <= 1'b0;
            comb_valid <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                comb_out[c] <= '0;
                for (int k = 0; k < CIC_ORDER; k++) begin
                    integ[c][k]    <= '0;
                    comb_dly[c][k] <= '0;
                end
            end
        end else begin
            dec_cnt    <= tick ? 7'd0 : dec_cnt + 7'd1;
            tick_d     <= tick;
            live_d     <= tick && (warm_cnt == 3'(CIC_ORDER));
            comb_valid <= live_d;
            if (tick && (warm_cnt != 3'(CIC_ORDER)))
                warm_cnt <= warm_cnt + 3'd1;
            for (int c = 0; c < CHANNELS; c++) begin
                integ[c][0] <= integ[c][0] + (pdm_din[c] ? acc_t'(1) : acc_t'(-1));
                for (int k = 1; k < CIC_ORDER; k++)
                    integ[c][k] <= integ[c][k] + integ[c][k-1];
                if (tick_d) begin
                    comb_dly[c][0] <= integ[c][CIC_ORDER-1];
                    for (int k = 1; k < CIC_ORDER; k++)
                        comb_dly[c][k] <= comb_stage[c][k-1];
                    comb_out[c] <= comb_stage[c][CIC_ORDER-1];
                end
            end
        end
    end

    always_comb begin
        acc_t shifted;
        for (int c = 0; c < CHANNELS; c++) begin
            shifted = comb_out[c] >>> shamt;
            if (shifted > SAT_MAX)
                scaled[c] = SAT_MAX[OUT_W-1:0];
            else if (shifted < SAT_MIN)
                scaled[c] = SAT_MIN[OUT_W-1:0];
            else
                scaled[c] = shifted[OUT_W-1:0];
        end
    end

    // Lowest enabled, highest enabled, and next enabled channel above the current one.
    always_comb begin
        first_ch = '0;
        last_ch  = '0;
        next_ch  = cur_ch;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (ch_en_q[i]) first_ch = 3'(i);
            if (ch_en_q[i] && (3'(i) > cur_ch)) next_ch = 3'(i);
        end
        for (int i = 0; i < CHANNELS; i++)
            if (ch_en_q[i]) last_ch = 3'(i);
    end

    assign load = comb_valid && (state == IDLE);
    assign drop = enable && comb_valid && (state == SEND);

    always_comb begin
        state_nxt  = state;
        cur_ch_nxt = cur_ch;
        case (state)
            IDLE: if (load && (|ch_en_q)) begin
                state_nxt  = SEND;
                cur_ch_nxt = first_ch;
            end
            SEND: if (pcm_ready) begin
                if (cur_ch == last_ch) state_nxt  = IDLE;
                else                   cur_ch_nxt = next_ch;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pdm_clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cur_ch <= '0;
            for (int c = 0; c < CHANNELS; c++) fbuf[c] <= '0;
        end else if (!enable) begin
            state  <= IDLE;
            cur_ch <= '0;
            for (int c = 0; c < CHANNELS; c++) fbuf[c] <= '0;
        end else begin
            state  <= state_nxt;
            cur_ch <= cur_ch_nxt;
            if (load)
                for (int c = 0; c < CHANNELS; c++) fbuf[c] <= scaled[c];
        end
    end

    // A drop that coincides with ovr_clr still leaves the flag set.
    always_ff @(posedge pdm_clk or negedge rst_n) begin
        if (!rst_n)       overrun <= 1'b0;
        else if (drop)    overrun <= 1'b1;
        else if (ovr_clr) overrun <= 1'b0;
    end

    always_comb begin
        pcm_data = '0;
        for (int c = 0; c < CHANNELS; c++)
            if (cur_ch == 3'(c)) pcm_data = fbuf[c];
    end

    assign pcm_valid = (state == SEND);
    assign pcm_ch    = cur_ch;
    assign pcm_last  = (state == SEND) && (cur_ch == last_ch);

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Directed bench for pdm_cic_decimator (4 channels, order 4, 16-bit PCM): frame timing,
// scaling/saturation, channel masking, overrun, config freezing and asynchronous reset.
module tb_pdm_cic_decimator;

    logic        pdm_clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [1:0]  osr_sel;
    logic [3:0]  ch_en;
    logic [3:0]  pdm_din;
    logic        pcm_ready;
    logic        ovr_clr;
    logic        pcm_valid;
    logic [15:0] pcm_data;
    logic [2:0]  pcm_ch;
    logic        pcm_last;
    logic        overrun;

    int checks = 0;
    int errors = 0;
    logic alt_mode = 1'b0;

    pdm_cic_decimator #(.CHANNELS(4), .CIC_ORDER(4), .OUT_W(16)) dut (
        .pdm_clk   (pdm_clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .osr_sel   (osr_sel),
        .ch_en     (ch_en),
        .pdm_din   (pdm_din),
        .pcm_ready (pcm_ready),
        .ovr_clr   (ovr_clr),
        .pcm_valid (pcm_valid),
        .pcm_data  (pcm_data),
        .pcm_ch    (pcm_ch),
        .pcm_last  (pcm_last),
        .overrun   (overrun)
    );

    always #5 pdm_clk = ~pdm_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, sampling 1 time unit after the last one.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            if (alt_mode) pdm_din = ~pdm_din;
            @(posedge pdm_clk);
            #1;
        end
    endtask

    // Stop, load configuration, then start; the next edge captures bit 1.
    task automatic start(input logic [1:0] osr, input logic [3:0] en, input logic [3:0] din);
        enable  = 1'b0;
        osr_sel = osr;
        ch_en   = en;
        pdm_din = din;
        step(2);
        enable = 1'b1;
    endtask

    initial begin
        logic seen;
        rst_n = 1'b0; enable = 1'b0; osr_sel = 2'd0; ch_en = 4'h0;
        pdm_din = 4'h0; pcm_ready = 1'b1; ovr_clr = 1'b0;
        step(3);
        check("rst_valid",   32'(pcm_valid), 32'd0);
        check("rst_data",    32'(pcm_data),  32'd0);
        check("rst_ch",      32'(pcm_ch),    32'd0);
        check("rst_last",    32'(pcm_last),  32'd0);
        check("rst_overrun", 32'(overrun),   32'd0);
        rst_n = 1'b1;

        // R=64, all ones: first frame ticks at bit 320, valid after edge 322.
        start(2'd1, 4'hF, 4'hF);
        step(321);
        check("r64_pre_valid", 32'(pcm_valid), 32'd0);
        step(1);
        check("r64_b0_valid", 32'(pcm_valid), 32'd1);
        check("r64_b0_ch",    32'(pcm_ch),    32'd0);
        check("r64_b0_data",  32'(pcm_data),  32'h7FFF);
        check("r64_b0_last",  32'(pcm_last),  32'd0);
        step(1);
        check("r64_b1_ch",    32'(pcm_ch),    32'd1);
        step(1);
        check("r64_b2_data",  32'(pcm_data),  32'h7FFF);
        step(1);
        check("r64_b3_ch",    32'(pcm_ch),    32'd3);
        check("r64_b3_last",  32'(pcm_last),  32'd1);
        check("r64_b3_data",  32'(pcm_data),  32'h7FFF);
        step(1);
        check("r64_post_valid", 32'(pcm_valid), 32'd0);
        step(59);
        check("r64_gap_valid",  32'(pcm_valid), 32'd0);
        step(1);
        check("r64_f2_valid",   32'(pcm_valid), 32'd1);

        // R=64, all zeros: negative full scale.
        start(2'd1, 4'hF, 4'h0);
        step(322);
        check("neg_valid", 32'(pcm_valid), 32'd1);
        check("neg_b0",    32'(pcm_data),  32'h8000);
        step(3);
        check("neg_b3",    32'(pcm_data),  32'h8000);
        check("neg_last",  32'(pcm_last),  32'd1);

        // R=128, alternating bits: zero once past warm-up; first frame at bit 640.
        alt_mode = 1'b1;
        start(2'd2, 4'hF, 4'h0);
        step(641);
        check("alt_pre_valid", 32'(pcm_valid), 32'd0);
        step(1);
        check("alt_valid", 32'(pcm_valid), 32'd1);
        check("alt_b0",    32'(pcm_data),  32'h0000);
        step(3);
        check("alt_b3",    32'(pcm_data),  32'h0000);
        alt_mode = 1'b0;

        // Sparse mask 1010 at R=32: beats ch1 then ch3.
        start(2'd0, 4'b1010, 4'hF);
        step(162);
        check("mask_b0_valid", 32'(pcm_valid), 32'd1);
        check("mask_b0_ch",    32'(pcm_ch),    32'd1);
        check("mask_b0_last",  32'(pcm_last),  32'd0);
        check("mask_b0_data",  32'(pcm_data),  32'h7FFF);
        step(1);
        check("mask_b1_ch",    32'(pcm_ch),    32'd3);
        check("mask_b1_last",  32'(pcm_last),  32'd1);
        step(1);
        check("mask_done",     32'(pcm_valid), 32'd0);

        // Empty mask: no beats at all.
        start(2'd0, 4'h0, 4'hF);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step(1);
            seen = seen | pcm_valid;
        end
        check("nomask_valid_seen", 32'(seen), 32'd0);

        // Overrun with ready held low.
        pcm_ready = 1'b0;
        start(2'd0, 4'hF, 4'hF);
        step(162);
        check("ovr_first_valid", 32'(pcm_valid), 32'd1);
        check("ovr_initial",     32'(overrun),   32'd0);
        step(31);
        check("ovr_before_drop", 32'(overrun),   32'd0);
        step(1);
        check("ovr_set",         32'(overrun),   32'd1);
        check("ovr_hold_valid",  32'(pcm_valid), 32'd1);
        check("ovr_hold_ch",     32'(pcm_ch),    32'd0);
        check("ovr_hold_data",   32'(pcm_data),  32'h7FFF);
        ovr_clr = 1'b1;
        step(1);
        check("ovr_cleared",     32'(overrun),   32'd0);
        ovr_clr = 1'b0;
        step(30);
        ovr_clr = 1'b1;
        step(1);
        check("ovr_set_wins",    32'(overrun),   32'd1);
        ovr_clr = 1'b0;
        pcm_ready = 1'b1;
        step(1);
        check("ovr_drain_ch1",   32'(pcm_ch),    32'd1);
        step(2);
        check("ovr_drain_last",  32'(pcm_last),  32'd1);
        step(1);
        check("ovr_drain_done",  32'(pcm_valid), 32'd0);

        // osr_sel change mid-run is ignored; overrun survives enable=0.
        start(2'd0, 4'hF, 4'hF);
        check("ovr_kept_disable", 32'(overrun), 32'd1);
        step(162);
        check("frz_f1_valid", 32'(pcm_valid), 32'd1);
        osr_sel = 2'd2;
        step(31);
        check("frz_gap_valid", 32'(pcm_valid), 32'd0);
        step(1);
        check("frz_f2_valid",  32'(pcm_valid), 32'd1);

        // Restart picks up R=128; enable falling mid-frame withdraws the beat.
        start(2'd2, 4'hF, 4'hF);
        step(641);
        check("r128_pre_valid", 32'(pcm_valid), 32'd0);
        step(1);
        check("r128_valid", 32'(pcm_valid), 32'd1);
        check("r128_data",  32'(pcm_data),  32'h7FFF);
        step(1);
        check("r128_b1_ch", 32'(pcm_ch),    32'd1);
        enable = 1'b0;
        step(1);
        check("abort_valid", 32'(pcm_valid), 32'd0);
        check("abort_data",  32'(pcm_data),  32'd0);

        // Asynchronous reset mid-beat, then warm-up is repeated.
        start(2'd0, 4'hF, 4'hF);
        step(162);
        check("prerst_valid",   32'(pcm_valid), 32'd1);
        check("prerst_overrun", 32'(overrun),   32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid",   32'(pcm_valid), 32'd0);
        check("arst_data",    32'(pcm_data),  32'd0);
        check("arst_ch",      32'(pcm_ch),    32'd0);
        check("arst_last",    32'(pcm_last),  32'd0);
        check("arst_overrun", 32'(overrun),   32'd0);
        enable = 1'b0;
        step(2);
        rst_n = 1'b1;
        start(2'd0, 4'hF, 4'hF);
        step(161);
        check("rewarm_pre_valid", 32'(pcm_valid), 32'd0);
        step(1);
        check("rewarm_valid", 32'(pcm_valid), 32'd1);
        check("rewarm_data",  32'(pcm_data),  32'h7FFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
